// File: rtl/result_uart_pkg.sv
// result_uart_pkg: shared state encoding, ASCII constants and nibble-to-hex helper
package result_uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam int NUM_CHARS = 10;
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    return n < 4'd10 ? {4'h3, n} : 8'h37 + {4'h0, n};
  endfunction
endpackage

// File: rtl/result_uart_reporter_tx.sv
// uart_tx_byte: byte serializer, start/data_in accepted when ready, tx idles high
// Ports: clk, rst (sync, active-high), start, data_in[7:0] in; tx, ready out.
// ready is high in IDLE and in the last cycle of a stop bit, so a new byte can
// follow the previous stop bit with no idle gap.
// Macro RESULT_UART_PARITY_EN inserts an even-parity bit between data and stop.
module uart_tx_byte
  import result_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data_in,
  output logic       tx,
  output logic       ready
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  state_t state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] data_q, data_d;
  logic tx_q, tx_d, last;
  assign last = bit_cnt_q == CW'(CLKS_PER_BIT - 1);
  assign ready = state_q == IDLE || (state_q == STOP && last);
  assign tx = tx_q;
  always_comb begin
    state_d = state_q;
    bit_idx_d = bit_idx_q;
    data_d = data_q;
    tx_d = tx_q;
    bit_cnt_d = (state_q == IDLE || last) ? '0 : bit_cnt_q + 1'b1;
    case (state_q)
      IDLE: if (start) begin
        state_d = START;
        tx_d = 1'b0;
        data_d = data_in;
        bit_idx_d = 3'd0;
      end
      START: if (last) begin
        state_d = DATA;
        tx_d = data_q[0];
      end
      DATA: if (last) begin
        bit_idx_d = bit_idx_q + 3'd1;
        if (bit_idx_q == 3'd7) begin
`ifdef RESULT_UART_PARITY_EN
          state_d = PARITY;
          tx_d = ^data_q;
`else
          state_d = STOP;
          tx_d = 1'b1;
`endif
        end else tx_d = data_q[bit_idx_q + 3'd1];
      end
      PARITY: if (last) begin
        state_d = STOP;
        tx_d = 1'b1;
      end
      STOP: if (last) begin
        state_d = start ? START : IDLE;
        tx_d = ~start;
        data_d = start ? data_in : data_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      data_q <= '0;
      tx_q <= 1'b1;
    end else begin
      state_q <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      data_q <= data_d;
      tx_q <= tx_d;
    end
  end
endmodule

// File: rtl/result_uart_reporter.sv
// result_uart_reporter: on a done rising edge, sends mem_word_0 as 8 hex chars + CR LF over UART
// Ports: clk, reset (sync, active-high), done, mem_word_0[31:0] in;
//        tx (idle high), busy (capture until last stop bit ends), sent (1-cycle pulse) out.
// Macro RESULT_UART_PARITY_EN selects 8E1 framing instead of 8N1.
module result_uart_reporter
  import result_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        done,
  input  logic [31:0] mem_word_0,
  output logic        tx,
  output logic        busy,
  output logic        sent
);
  logic done_q, busy_q, busy_d, sent_q, sent_d;
  logic [3:0] char_idx_q, char_idx_d, next_idx;
  logic [31:0] word_q, word_d, src, shifted;
  logic capture, advance, more, start, ready;
  logic [7:0] char_data;
  always_comb begin
    capture = done && !done_q && !busy_q;
    advance = busy_q && ready;
    more = char_idx_q < 4'(NUM_CHARS - 1);
    start = capture || (advance && more);
    next_idx = capture ? 4'd0 : char_idx_q + 4'd1;
    // the first character is taken straight from mem_word_0 so tx can fall on the capture edge
    src = capture ? mem_word_0 : word_q;
    shifted = src << {next_idx, 2'b00};
    char_data = next_idx == 4'd8 ? ASCII_CR : next_idx == 4'd9 ? ASCII_LF : nibble_to_ascii(shifted[31:28]);
    char_idx_d = start ? next_idx : char_idx_q;
    word_d = capture ? mem_word_0 : word_q;
    sent_d = advance && !more;
    busy_d = capture || (busy_q && !sent_d);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      done_q <= 1'b0;
      busy_q <= 1'b0;
      sent_q <= 1'b0;
      char_idx_q <= '0;
      word_q <= '0;
    end else begin
      done_q <= done;
      busy_q <= busy_d;
      sent_q <= sent_d;
      char_idx_q <= char_idx_d;
      word_q <= word_d;
    end
  end
  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk(clk),
    .rst(reset),
    .start(start),
    .data_in(char_data),
    .tx(tx),
    .ready(ready)
  );
  assign busy = busy_q;
  assign sent = sent_q;
endmodule

// File: tb/tb_result_uart_reporter.sv
// tb_result_uart_reporter: directed vectors decoding the UART report at CLKS_PER_BIT 4 and 2
module tb_result_uart_reporter;
`ifdef RESULT_UART_PARITY_EN
  localparam int BITS = 11;
`else
  localparam int BITS = 10;
`endif
  logic clk = 1'b0, reset = 1'b1, done4 = 1'b0, done2 = 1'b0;
  logic [31:0] w4 = '0, w2 = '0;
  logic tx4, busy4, sent4, tx2, busy2, sent2;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  result_uart_reporter #(.CLKS_PER_BIT(4)) dut4 (.clk(clk), .reset(reset), .done(done4), .mem_word_0(w4), .tx(tx4), .busy(busy4), .sent(sent4));
  result_uart_reporter #(.CLKS_PER_BIT(2)) dut2 (.clk(clk), .reset(reset), .done(done2), .mem_word_0(w2), .tx(tx2), .busy(busy2), .sent(sent2));
  typedef struct {logic [31:0] word; int cpb; logic [79:0] exp;} vec_t;
  vec_t v[4];
  function automatic logic txs(int cpb); return cpb == 2 ? tx2 : tx4; endfunction
  function automatic logic busys(int cpb); return cpb == 2 ? busy2 : busy4; endfunction
  function automatic logic sents(int cpb); return cpb == 2 ? sent2 : sent4; endfunction
  task automatic set_done(int cpb, logic val);
    if (cpb == 2) done2 = val; else done4 = val;
  endtask
  task automatic set_word(int cpb, logic [31:0] val);
    if (cpb == 2) w2 = val; else w4 = val;
  endtask
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic kick(int cpb, string name);
    @(negedge clk) set_done(cpb, 1'b0);
    @(negedge clk) set_done(cpb, 1'b1);
    @(negedge clk);
    chk({name, " start tx"}, 32'(txs(cpb)), 0);
    chk({name, " start busy"}, 32'(busys(cpb)), 1);
  endtask
  // called at the negedge where the first start bit is already visible
  task automatic rx(int cpb, logic [79:0] exp, string name, bit chg, bit glitch);
    logic [10:0] bits;
    logic [7:0] got, e;
    int werr = 0, serr = 0;
    bits = '0;
    for (int c = 0; c < 10; c++) begin
      for (int b = 0; b < BITS; b++)
        for (int k = 0; k < cpb; k++) begin
          if (c != 0 || b != 0 || k != 0) @(negedge clk);
          if (k == 0) bits[b] = txs(cpb);
          else if (txs(cpb) !== bits[b]) werr++;
          if (busys(cpb) !== 1'b1 || sents(cpb) !== 1'b0) serr++;
          if (b == 0 && k == 0) begin
            if (chg && c == 2) set_word(cpb, 32'h12345678);
            if (glitch && c >= 2 && c <= 5) set_done(cpb, c[0]);
          end
        end
      got = bits[8:1];
      e = exp[79 - 8 * c -: 8];
      chk($sformatf("%s char%0d", name, c), 32'(got), 32'(e));
      chk($sformatf("%s frame%0d", name, c), {30'd0, bits[0], bits[BITS-1]}, 32'd1);
`ifdef RESULT_UART_PARITY_EN
      chk($sformatf("%s parity%0d", name, c), 32'(bits[9]), 32'(^e));
`endif
    end
    chk({name, " bit width"}, werr, 0);
    chk({name, " busy/sent during frame"}, serr, 0);
    @(negedge clk);
    chk({name, " sent pulse"}, {29'd0, sents(cpb), busys(cpb), txs(cpb)}, 32'b101);
    @(negedge clk);
    chk({name, " sent one cycle"}, 32'(sents(cpb)), 0);
  endtask
  initial begin
    int idle_err;
    v[0] = '{32'h0000002A, 4, 80'h30303030303032410D0A};
    v[1] = '{32'h89ABCDEF, 4, 80'h38394142434445460D0A};
    v[2] = '{32'h000000AF, 4, 80'h30303030303041460D0A};
    v[3] = '{32'hFFFFFFFF, 2, 80'h46464646464646460D0A};
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset tx4", 32'(tx4), 1);
    chk("reset busy4", 32'(busy4), 0);
    chk("reset sent4", 32'(sent4), 0);
    chk("reset tx2", 32'(tx2), 1);
    chk("reset busy2", 32'(busy2), 0);
    for (int i = 0; i < 4; i++) begin
      set_word(v[i].cpb, v[i].word);
      kick(v[i].cpb, $sformatf("vec%0d", i));
      rx(v[i].cpb, v[i].exp, $sformatf("vec%0d", i), 1'b0, 1'b0);
    end
    w4 = 32'hDEADBEEF;
    kick(4, "chg");
    rx(4, 80'h44454144424545460D0A, "chg", 1'b1, 1'b0);
    w4 = 32'h0000002A;
    kick(4, "glitch");
    rx(4, 80'h30303030303032410D0A, "glitch", 1'b0, 1'b1);
    idle_err = 0;
    repeat (20) @(negedge clk) if (busy4 !== 1'b0 || tx4 !== 1'b1 || sent4 !== 1'b0) idle_err++;
    chk("no second report", idle_err, 0);
    kick(4, "fresh");
    rx(4, 80'h30303030303032410D0A, "fresh", 1'b0, 1'b0);
    kick(4, "rst");
    repeat (130) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst abort tx", 32'(tx4), 1);
    chk("rst abort busy", 32'(busy4), 0);
    chk("rst abort sent", 32'(sent4), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst restart tx", 32'(tx4), 0);
    chk("rst restart busy", 32'(busy4), 1);
    rx(4, 80'h30303030303032410D0A, "rst report", 1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
